// File: rtl/vga_scan_ctrl_if.sv
// Bus between the raster scan sequencer and its consumers (renderer, game logic).
// The speed field exists only when VGA_SCAN_SPEED_EN is defined.
interface vga_scan_ctrl_if #(
  parameter int X_W = 10,
  parameter int Y_W = 10
);
  logic           en;
`ifdef VGA_SCAN_SPEED_EN
  logic [1:0]     speed;
`endif
  logic           pix_en;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           hsync;
  logic           vsync;
  logic           active;
  logic           frame_start;
  logic           game_tick;

  modport master (
`ifdef VGA_SCAN_SPEED_EN
    input  speed,
`endif
    input  en,
    output pix_en, x, y, hsync, vsync, active, frame_start, game_tick
  );

  modport slave (
`ifdef VGA_SCAN_SPEED_EN
    output speed,
`endif
    output en,
    input  pix_en, x, y, hsync, vsync, active, frame_start, game_tick
  );
endinterface

// File: rtl/vga_scan_ctrl.sv
// Raster scan sequencer: pixel prescaler, cascaded x/y counters decoded into
// sync/blanking, plus a frame counter that issues game_tick.
// Optional macro VGA_SCAN_SPEED_EN adds a 2-bit speed input that shortens the
// game_tick period to max(1, TICK_FRAMES >> speed), sampled at frame_start.
module vga_scan_ctrl #(
  parameter int PIX_DIV     = 2,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int TICK_FRAMES = 8
) (
  input  logic            clk,
  input  logic            reset,
  vga_scan_ctrl_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int X_W     = $clog2(H_TOTAL);
  localparam int Y_W     = $clog2(V_TOTAL);
  localparam int PS_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int FC_W    = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;

  localparam logic [PS_W-1:0] PS_LAST     = PS_W'(PIX_DIV - 1);
  localparam logic [X_W-1:0]  X_LAST      = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0]  Y_LAST      = Y_W'(V_TOTAL - 1);
  // Last coordinate of each phase; phases are contiguous and in order.
  localparam logic [X_W-1:0]  H_ACT_LAST  = X_W'(H_ACTIVE - 1);
  localparam logic [X_W-1:0]  H_FP_LAST   = X_W'(H_ACTIVE + H_FP - 1);
  localparam logic [X_W-1:0]  H_SYN_LAST  = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [Y_W-1:0]  V_ACT_LAST  = Y_W'(V_ACTIVE - 1);
  localparam logic [Y_W-1:0]  V_FP_LAST   = Y_W'(V_ACTIVE + V_FP - 1);
  localparam logic [Y_W-1:0]  V_SYN_LAST  = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {HP_ACT, HP_FRONT, HP_SYNC, HP_BACK} h_phase_e;
  typedef enum logic [1:0] {VP_ACT, VP_FRONT, VP_SYNC, VP_BACK} v_phase_e;

  logic [PS_W-1:0] ps_q, ps_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic            pix_en, x_wrap, frame_start, game_tick;
  logic [31:0]     period;
  h_phase_e        h_phase;
  v_phase_e        v_phase;

  // State register: all counters clear on reset and hold while en is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ps_q <= '0;
      x_q  <= '0;
      y_q  <= '0;
      fc_q <= '0;
    end else begin
      ps_q <= ps_d;
      x_q  <= x_d;
      y_q  <= y_d;
      fc_q <= fc_d;
    end
  end

  // Next state: prescaler -> x -> y cascade, frame counter on frame_start.
  always_comb begin
    ps_d      = ps_q;
    x_d       = x_q;
    y_d       = y_q;
    fc_d      = fc_q;
    game_tick = 1'b0;

`ifdef VGA_SCAN_SPEED_EN
    period = 32'(TICK_FRAMES) >> bus.speed;
    if (period == 32'd0) period = 32'd1;
`else
    period = 32'(TICK_FRAMES);
`endif

    pix_en      = bus.en && (ps_q == PS_LAST);
    x_wrap      = pix_en && (x_q == X_LAST);
    frame_start = x_wrap && (y_q == Y_LAST);

    if (bus.en) ps_d = (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);

    if (pix_en) x_d = x_wrap ? '0 : x_q + X_W'(1);
    if (x_wrap) y_d = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);

    // A shortened period can leave the counter beyond its new last value;
    // that frame wraps silently rather than issuing a late tick.
    if (frame_start) begin
      if (32'(fc_q) >= period) begin
        fc_d = '0;
      end else if (32'(fc_q) == period - 32'd1) begin
        fc_d      = '0;
        game_tick = 1'b1;
      end else begin
        fc_d = fc_q + FC_W'(1);
      end
    end
  end

  // Outputs: phase decode of the registered x/y, no added latency.
  always_comb begin
    if (x_q <= H_ACT_LAST)      h_phase = HP_ACT;
    else if (x_q <= H_FP_LAST)  h_phase = HP_FRONT;
    else if (x_q <= H_SYN_LAST) h_phase = HP_SYNC;
    else                        h_phase = HP_BACK;

    if (y_q <= V_ACT_LAST)      v_phase = VP_ACT;
    else if (y_q <= V_FP_LAST)  v_phase = VP_FRONT;
    else if (y_q <= V_SYN_LAST) v_phase = VP_SYNC;
    else                        v_phase = VP_BACK;

    bus.pix_en      = pix_en;
    bus.x           = x_q;
    bus.y           = y_q;
    bus.hsync       = (h_phase != HP_SYNC);
    bus.vsync       = (v_phase != VP_SYNC);
    bus.active      = (h_phase == HP_ACT) && (v_phase == VP_ACT);
    bus.frame_start = frame_start;
    bus.game_tick   = game_tick;
  end
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl: a default-timing instance, a tiny-geometry
// instance (8x6 totals, PIX_DIV=1, TICK_FRAMES=3) and, with VGA_SCAN_SPEED_EN,
// a tiny-geometry instance with TICK_FRAMES=8 for the speed control.
module tb_vga_scan_ctrl;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   fs_cnt;
  int   gt_cnt;

  vga_scan_ctrl_if #(.X_W(10), .Y_W(10)) d_if ();
  vga_scan_ctrl_if #(.X_W(3),  .Y_W(3))  s_if ();

  vga_scan_ctrl u_dflt (
    .clk   (clk),
    .reset (reset),
    .bus   (d_if)
  );

  vga_scan_ctrl #(
    .PIX_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .TICK_FRAMES(3)
  ) u_small (
    .clk   (clk),
    .reset (reset),
    .bus   (s_if)
  );

`ifdef VGA_SCAN_SPEED_EN
  vga_scan_ctrl_if #(.X_W(3), .Y_W(3)) f_if ();

  vga_scan_ctrl #(
    .PIX_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .TICK_FRAMES(8)
  ) u_speed (
    .clk   (clk),
    .reset (reset),
    .bus   (f_if)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    d_if.en  = 1'b1;
    s_if.en  = 1'b1;
`ifdef VGA_SCAN_SPEED_EN
    d_if.speed = 2'd0;
    s_if.speed = 2'd0;
    f_if.speed = 2'd0;
    f_if.en    = 1'b1;
`endif
    step(2);

    // Reset state
    check("rst_d_x",      32'(d_if.x), 0);
    check("rst_d_y",      32'(d_if.y), 0);
    check("rst_d_pix_en", 32'(d_if.pix_en), 0);
    check("rst_d_hsync",  32'(d_if.hsync), 1);
    check("rst_d_vsync",  32'(d_if.vsync), 1);
    check("rst_d_active", 32'(d_if.active), 1);
    check("rst_d_fs",     32'(d_if.frame_start), 0);
    check("rst_d_gt",     32'(d_if.game_tick), 0);
    check("rst_s_pix_en", 32'(s_if.pix_en), 1);
    check("rst_s_x",      32'(s_if.x), 0);
    reset = 1'b1;

    // First line of the default timing, whole frames of the small one
    fs_cnt = 0;
    gt_cnt = 0;
    for (int k = 1; k <= 1600; k++) begin
      step(1);
      case (k)
        1:    begin check("d_pix_en_k1", 32'(d_if.pix_en), 1); check("d_x_k1", 32'(d_if.x), 0); end
        2:    begin check("d_pix_en_k2", 32'(d_if.pix_en), 0); check("d_x_k2", 32'(d_if.x), 1); end
        1279: begin check("d_x_639", 32'(d_if.x), 639); check("d_active_639", 32'(d_if.active), 1); end
        1280: begin check("d_x_640", 32'(d_if.x), 640); check("d_active_640", 32'(d_if.active), 0); end
        1311: begin check("d_x_655", 32'(d_if.x), 655); check("d_hsync_655", 32'(d_if.hsync), 1); end
        1312: begin check("d_x_656", 32'(d_if.x), 656); check("d_hsync_656", 32'(d_if.hsync), 0); end
        1503: begin check("d_x_751", 32'(d_if.x), 751); check("d_hsync_751", 32'(d_if.hsync), 0); end
        1504: begin check("d_x_752", 32'(d_if.x), 752); check("d_hsync_752", 32'(d_if.hsync), 1); end
        1599: begin
          check("d_x_799", 32'(d_if.x), 799);
          check("d_y_799", 32'(d_if.y), 0);
          check("d_pix_en_799", 32'(d_if.pix_en), 1);
          check("d_fs_799", 32'(d_if.frame_start), 0);
        end
        1600: begin check("d_x_wrap", 32'(d_if.x), 0); check("d_y_wrap", 32'(d_if.y), 1); end
        default: ;
      endcase

      if (s_if.frame_start) fs_cnt++;
      if (s_if.game_tick)   gt_cnt++;
      if (k % 48 == 47) begin
        check("s_fs_last", 32'(s_if.frame_start), 1);
        check("s_x_last",  32'(s_if.x), 7);
        check("s_y_last",  32'(s_if.y), 5);
        check("s_gt_last", 32'(s_if.game_tick), 32'(k % 144 == 143));
      end
      if (k % 48 == 0) begin
        check("s_x_origin", 32'(s_if.x), 0);
        check("s_y_origin", 32'(s_if.y), 0);
      end
      if (k % 8 == 0) check("s_vsync_line", 32'(s_if.vsync), 32'(((k / 8) % 6) != 4));
    end
    check("s_fs_count", 32'(fs_cnt), 33);
    check("s_gt_count", 32'(gt_cnt), 11);

    // en dropped at x=5, y=2 on the small instance
    step(5);
    check("s_x_pre_hold", 32'(s_if.x), 5);
    check("s_y_pre_hold", 32'(s_if.y), 2);
    s_if.en = 1'b0;
    #1;
    check("s_pix_en_off", 32'(s_if.pix_en), 0);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("s_x_hold",      32'(s_if.x), 5);
      check("s_y_hold",      32'(s_if.y), 2);
      check("s_pix_en_hold", 32'(s_if.pix_en), 0);
      check("s_fs_hold",     32'(s_if.frame_start), 0);
      check("s_gt_hold",     32'(s_if.game_tick), 0);
    end
    check("s_hsync_hold",  32'(s_if.hsync), 0);
    check("s_active_hold", 32'(s_if.active), 0);
    s_if.en = 1'b1;
    #1;
    check("s_pix_en_on", 32'(s_if.pix_en), 1);
    step(1);
    check("s_x_resume", 32'(s_if.x), 6);
    check("s_y_resume", 32'(s_if.y), 2);

    // en dropped exactly on a ticking frame_start suppresses both pulses
    step(121);
    check("s_fs_pre_gate", 32'(s_if.frame_start), 1);
    check("s_gt_pre_gate", 32'(s_if.game_tick), 1);
    s_if.en = 1'b0;
    #1;
    check("s_fs_gated",     32'(s_if.frame_start), 0);
    check("s_gt_gated",     32'(s_if.game_tick), 0);
    check("s_pix_en_gated", 32'(s_if.pix_en), 0);
    step(3);
    check("s_x_gated", 32'(s_if.x), 7);
    check("s_y_gated", 32'(s_if.y), 5);
    s_if.en = 1'b1;
    #1;
    check("s_gt_ungated", 32'(s_if.game_tick), 1);
    step(1);
    check("s_x_after_gate",  32'(s_if.x), 0);
    check("s_y_after_gate",  32'(s_if.y), 0);
    check("s_gt_after_gate", 32'(s_if.game_tick), 0);

    // Mid-frame reset with the frame counter at its last value
    step(116);
    check("s_x_pre_rst", 32'(s_if.x), 4);
    check("s_y_pre_rst", 32'(s_if.y), 2);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    check("mrst_s_x",      32'(s_if.x), 0);
    check("mrst_s_y",      32'(s_if.y), 0);
    check("mrst_s_hsync",  32'(s_if.hsync), 1);
    check("mrst_s_vsync",  32'(s_if.vsync), 1);
    check("mrst_s_active", 32'(s_if.active), 1);
    check("mrst_s_fs",     32'(s_if.frame_start), 0);
    check("mrst_s_gt",     32'(s_if.game_tick), 0);
    check("mrst_d_x",      32'(d_if.x), 0);
    check("mrst_d_y",      32'(d_if.y), 0);
    check("mrst_d_pix_en", 32'(d_if.pix_en), 0);
    gt_cnt = 0;
    for (int k = 1; k <= 143; k++) begin
      step(1);
      if (k < 143 && s_if.game_tick) gt_cnt++;
      if (k % 48 == 47) begin
        check("mrst_fs", 32'(s_if.frame_start), 1);
        check("mrst_gt", 32'(s_if.game_tick), 32'(k == 143));
      end
    end
    check("mrst_gt_early", 32'(gt_cnt), 0);

`ifdef VGA_SCAN_SPEED_EN
    // speed=2 -> every 2nd frame; then speed=0 up to frame_cnt=5; then speed=3
    f_if.speed = 2'd2;
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    gt_cnt = 0;
    for (int k = 1; k <= 575; k++) begin
      step(1);
      f_if.speed = (k <= 191) ? 2'd2 : ((k <= 440) ? 2'd0 : 2'd3);
      #1;
      if (f_if.game_tick) gt_cnt++;
      if (k % 48 == 47) begin
        check("spd_fs", 32'(f_if.frame_start), 1);
        check("spd_gt", 32'(f_if.game_tick),
              32'((k == 95) || (k == 191) || (k == 527) || (k == 575)));
      end
    end
    check("spd_gt_count", 32'(gt_cnt), 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
